obuf_drain: RTL and testbench
=============================

# obuf_drain

Output buffer for the array datapath, the write-from-array / read-to-memory counterpart of the input buffer. Array result columns are written with a per-column systolic skew: the request enters column 0 and is forwarded one register stage per column. A drain sequencer reads the buffer back in MEM_DATA_WIDTH words and streams them to the memory interface over a valid/ready handshake with a skid FIFO.

## Interface
Parameters:
- MEM_DATA_WIDTH, 64, memory-side word width
- ARRAY_N, 4, array columns (one bank per column)
- DATA_WIDTH, 32, per-column element width
- BUF_ADDR_WIDTH, 10, per-bank address width
- GROUP_SIZE, MEM_DATA_WIDTH/DATA_WIDTH, columns per memory word
- GROUP_ID_W, GROUP_SIZE==1 ? 0 : $clog2(GROUP_SIZE)
- BUF_ID_W, $clog2(ARRAY_N)-GROUP_ID_W, group-select bits
- MEM_ADDR_WIDTH, BUF_ADDR_WIDTH+BUF_ID_W
- BUF_DATA_WIDTH, ARRAY_N*DATA_WIDTH

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low
- buf_write_req  in  1  array write request, enters column 0
- buf_write_addr  in  BUF_ADDR_WIDTH  bank address, forwarded with req
- buf_write_data  in  BUF_DATA_WIDTH  slice n = column n data, sampled when req reaches column n
- drain_start  in  1  one-cycle pulse, starts a drain
- drain_base  in  MEM_ADDR_WIDTH  first memory address
- drain_count  in  MEM_ADDR_WIDTH+1  number of words
- drain_busy  out  1  drain in progress
- drain_done  out  1  one-cycle pulse at completion
- mem_read_valid  out  1  word available
- mem_read_ready  in  1  consumer accepts
- mem_read_data  out  MEM_DATA_WIDTH  word
- mem_read_addr  out  MEM_ADDR_WIDTH  memory address of current word

## Operation
- Write skew: req/addr registered once per column; column n writes bank n at cycle t+n for a req at t, using buf_write_data[n*DATA_WIDTH+:DATA_WIDTH] at t+n.
- Address map: memory address a = {local_addr, group}; group = a[BUF_ID_W-1:0] selects columns group*GROUP_SIZE .. +GROUP_SIZE-1; column (group*GROUP_SIZE+k) occupies bits k*DATA_WIDTH. With BUF_ID_W==0 the address is local_addr, single group.
- FSM: IDLE -> (drain_start, count>0) ISSUE; IDLE -> (drain_start, count==0) done pulse, stay IDLE. ISSUE issues one read per cycle while (FIFO occupancy + in-flight) < 4; after last issue -> FLUSH. FLUSH -> IDLE when FIFO empty and nothing in flight; drain_done pulses that transition.
- Address increments mod 2^MEM_ADDR_WIDTH (wrap to 0).
- drain_start while busy: ignored. Drain parameters latched at start.
- Same-cycle write and drain read to the same bank address: read returns old data.
- Reset (any time, incl. mid-drain): FSM IDLE, FIFO flushed, forwarding regs cleared (no pending writes), outputs zero. Bank contents not reset.

## Timing
- Reset values: drain_busy 0, drain_done 0, mem_read_valid 0, mem_read_data 0, mem_read_addr 0.
- drain_start at t: drain_busy 1 from t+1; first read issued t+1; bank read latency 1; first mem_read_valid at t+3.
- Ready held high: one word per cycle, no bubbles; last word at t+2+count; drain_done at t+3+count, drain_busy falls same cycle.
- Valid held and data/addr stable while ready low; transfer on valid&&ready only.
- Write at column n visible to drain reads issued from t+n+1.

## Structure
- Shared package: FSM state enum (IDLE, ISSUE, FLUSH), SKID_DEPTH=4 constant, address split helper widths.
- Sub-module obuf_bank: simple dual-port DATA_WIDTH x 2^BUF_ADDR_WIDTH RAM, one write port, one registered read port; instantiated ARRAY_N times. Skid FIFO and FSM stay in top.

## Test plan
- ARRAY_N=4, GROUP_SIZE=2: req at t addr 5, column n data 0x100+n at t+n; drain base 10 count 2 -> words 0x00000101_00000100 (addr 10), 0x00000103_00000102 (addr 11).
- Fill 16 words, drain count 16 with ready high -> 16 consecutive valid cycles from t+3, drain_done at t+19.
- Same drain with ready low 10 cycles then toggling -> every word exactly once, in order, stable under stall.
- drain_count 0 -> drain_done at t+1, drain_busy stays 0, no valid.
- base 2^MEM_ADDR_WIDTH-1 count 2 -> mem_read_addr max then 0; drain_start while busy -> ignored, count unchanged.
- Assert reset mid-drain with 2 words in FIFO -> all outputs 0 immediately; new drain after release returns correct data.

Source files
------------

// File: rtl/obuf_drain_pkg.sv
`default_nettype none
// ============================================================================
// Module      : obuf_drain_pkg
// Description : Shared types and constants for the output-buffer drain path.
// Revision    : 1.0  initial release
// ============================================================================
package obuf_drain_pkg;

   // Drain sequencer states
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_FLUSH = 2'd2
   } state_t;

   // Skid FIFO depth; also bounds reads outstanding (FIFO + in flight)
   localparam int SKID_DEPTH = 4;

   // Bits of the memory address that select a column within a group
   function automatic int f_group_id_w(input int group_size);
      return (group_size == 1) ? 0 : $clog2(group_size);
   endfunction

   // Bits of the memory address that select the column group
   function automatic int f_buf_id_w(input int array_n, input int group_id_w);
      return $clog2(array_n) - group_id_w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/obuf_bank.sv
`default_nettype none
// ============================================================================
// Module      : obuf_bank
// Description : Simple dual-port RAM, one write port and one registered read
//               port. A same-address read and write returns the old data.
// Revision    : 1.0  initial release
// ============================================================================
module obuf_bank
   import obuf_drain_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  i_we,
   input  logic [ADDR_WIDTH-1:0] i_waddr,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   input  logic                  i_re,
   input  logic [ADDR_WIDTH-1:0] i_raddr,
   output logic [DATA_WIDTH-1:0] o_rdata
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [DATA_WIDTH-1:0] r_rdata;

   // Storage is not reset; read register samples pre-write contents
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
      if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/obuf_drain.sv
`default_nettype none
// ============================================================================
// Module      : obuf_drain
// Description : Column-skewed output buffer with a drain sequencer that reads
//               memory-width words and streams them through a skid FIFO.
// Revision    : 1.0  initial release
// ============================================================================
module obuf_drain
   import obuf_drain_pkg::*;
#(
   parameter int MEM_DATA_WIDTH = 64,
   parameter int ARRAY_N        = 4,
   parameter int DATA_WIDTH     = 32,
   parameter int BUF_ADDR_WIDTH = 10,
   parameter int GROUP_SIZE     = MEM_DATA_WIDTH / DATA_WIDTH,
   parameter int GROUP_ID_W     = f_group_id_w(GROUP_SIZE),
   parameter int BUF_ID_W       = f_buf_id_w(ARRAY_N, GROUP_ID_W),
   parameter int MEM_ADDR_WIDTH = BUF_ADDR_WIDTH + BUF_ID_W,
   parameter int BUF_DATA_WIDTH = ARRAY_N * DATA_WIDTH
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      buf_write_req,
   input  logic [BUF_ADDR_WIDTH-1:0] buf_write_addr,
   input  logic [BUF_DATA_WIDTH-1:0] buf_write_data,
   input  logic                      drain_start,
   input  logic [MEM_ADDR_WIDTH-1:0] drain_base,
   input  logic [MEM_ADDR_WIDTH:0]   drain_count,
   output logic                      drain_busy,
   output logic                      drain_done,
   output logic                      mem_read_valid,
   input  logic                      mem_read_ready,
   output logic [MEM_DATA_WIDTH-1:0] mem_read_data,
   output logic [MEM_ADDR_WIDTH-1:0] mem_read_addr
);

   localparam int NUM_GROUPS = ARRAY_N / GROUP_SIZE;
   localparam int GRP_W      = (BUF_ID_W > 0) ? BUF_ID_W : 1;
   localparam int PTR_W      = $clog2(SKID_DEPTH);
   localparam int CNT_W      = PTR_W + 1;

   // ---------------------------------------------------------------------
   // Write skew: column n sees the request n cycles after column 0
   // ---------------------------------------------------------------------
   logic                      w_col_req  [ARRAY_N];
   logic [BUF_ADDR_WIDTH-1:0] w_col_addr [ARRAY_N];
   logic [BUF_DATA_WIDTH-1:0] w_bank_flat;

   logic                      w_issue;
   logic [BUF_ADDR_WIDTH-1:0] w_issue_local;
   logic [GRP_W-1:0]          w_issue_group;

   generate
      for (genvar n = 0; n < ARRAY_N; n++) begin : g_col
         if (n == 0) begin : g_head
            assign w_col_req[0]  = buf_write_req;
            assign w_col_addr[0] = buf_write_addr;
         end else begin : g_fwd
            logic                      r_req;
            logic [BUF_ADDR_WIDTH-1:0] r_waddr;

            // Forward request and address one column per cycle
            always_ff @(posedge clk or negedge reset) begin
               if (!reset) begin
                  r_req   <= 1'b0;
                  r_waddr <= '0;
               end else begin
                  r_req   <= w_col_req[n-1];
                  r_waddr <= w_col_addr[n-1];
               end
            end

            assign w_col_req[n]  = r_req;
            assign w_col_addr[n] = r_waddr;
         end

         obuf_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (BUF_ADDR_WIDTH)
         ) u_bank (
            .clk     (clk),
            .i_we    (w_col_req[n]),
            .i_waddr (w_col_addr[n]),
            .i_wdata (buf_write_data[n*DATA_WIDTH +: DATA_WIDTH]),
            .i_re    (w_issue),
            .i_raddr (w_issue_local),
            .o_rdata (w_bank_flat[n*DATA_WIDTH +: DATA_WIDTH])
         );
      end
   endgenerate

   // ---------------------------------------------------------------------
   // Drain sequencer state
   // ---------------------------------------------------------------------
   state_t                    r_state;
   state_t                    w_state_nxt;
   logic                      w_start_accept;
   logic                      w_done_set;
   logic                      r_done;
   logic [MEM_ADDR_WIDTH-1:0] r_addr;
   logic [MEM_ADDR_WIDTH:0]   r_remaining;

   logic                      r_rd_valid;
   logic [MEM_ADDR_WIDTH-1:0] r_rd_addr;
   logic [GRP_W-1:0]          r_rd_group;
   logic [MEM_DATA_WIDTH-1:0] w_rd_word;

   logic [MEM_DATA_WIDTH-1:0] r_fifo_data [SKID_DEPTH];
   logic [MEM_ADDR_WIDTH-1:0] r_fifo_addr [SKID_DEPTH];
   logic [PTR_W-1:0]          r_wr_ptr;
   logic [PTR_W-1:0]          r_rd_ptr;
   logic [CNT_W-1:0]          r_fifo_cnt;
   logic                      w_push;
   logic                      w_pop;
   logic                      w_can_issue;

   // Address split: low bits pick the column group, the rest is the bank address
   generate
      if (BUF_ID_W > 0) begin : g_grp
         assign w_issue_group = r_addr[BUF_ID_W-1:0];
         assign w_issue_local = r_addr[MEM_ADDR_WIDTH-1:BUF_ID_W];
      end else begin : g_nogrp
         assign w_issue_group = '0;
         assign w_issue_local = r_addr;
      end
   endgenerate

   assign w_push      = r_rd_valid;
   assign w_pop       = (r_fifo_cnt != '0) && mem_read_ready;
   // Outstanding reads (queued plus the one in the bank register) stay within the FIFO
   assign w_can_issue = (r_fifo_cnt + CNT_W'(r_rd_valid)) < CNT_W'(SKID_DEPTH);

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and control decode; a new start is only honoured in IDLE
   always_comb begin
      w_state_nxt    = r_state;
      w_issue        = 1'b0;
      w_start_accept = 1'b0;
      w_done_set     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (drain_start) begin
               if (drain_count == '0) begin
                  w_done_set = 1'b1;
               end else begin
                  w_start_accept = 1'b1;
                  w_state_nxt    = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            if (w_can_issue) begin
               w_issue = 1'b1;
               if (r_remaining == (MEM_ADDR_WIDTH+1)'(1)) begin
                  w_state_nxt = S_FLUSH;
               end
            end
         end
         S_FLUSH: begin
            // Leave as the final word is accepted so busy drops with the done pulse
            if (!r_rd_valid &&
                ((r_fifo_cnt == '0) || ((r_fifo_cnt == CNT_W'(1)) && w_pop))) begin
               w_state_nxt = S_IDLE;
               w_done_set  = 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Latch drain parameters, advance address, track the read in the bank register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_addr      <= '0;
         r_remaining <= '0;
         r_rd_valid  <= 1'b0;
         r_rd_addr   <= '0;
         r_rd_group  <= '0;
         r_done      <= 1'b0;
      end else begin
         r_done     <= w_done_set;
         r_rd_valid <= w_issue;
         if (w_start_accept) begin
            r_addr      <= drain_base;
            r_remaining <= drain_count;
         end else if (w_issue) begin
            r_addr      <= r_addr + MEM_ADDR_WIDTH'(1);
            r_remaining <= r_remaining - (MEM_ADDR_WIDTH+1)'(1);
         end
         if (w_issue) begin
            r_rd_addr  <= r_addr;
            r_rd_group <= w_issue_group;
         end
      end
   end

   // Select the group's columns; group g is a contiguous slice of the bank outputs
   always_comb begin
      w_rd_word = w_bank_flat[MEM_DATA_WIDTH-1:0];
      for (int g = 1; g < NUM_GROUPS; g++) begin
         if (r_rd_group == GRP_W'(g)) begin
            w_rd_word = w_bank_flat[g*MEM_DATA_WIDTH +: MEM_DATA_WIDTH];
         end
      end
   end

   // Skid FIFO pointers and occupancy
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_fifo_cnt <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_fifo_cnt <= r_fifo_cnt + CNT_W'(1);
            2'b01:   r_fifo_cnt <= r_fifo_cnt - CNT_W'(1);
            default: r_fifo_cnt <= r_fifo_cnt;
         endcase
      end
   end

   // Skid FIFO storage
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_data[r_wr_ptr] <= w_rd_word;
         r_fifo_addr[r_wr_ptr] <= r_rd_addr;
      end
   end

   assign mem_read_valid = (r_fifo_cnt != '0);
   assign mem_read_data  = mem_read_valid ? r_fifo_data[r_rd_ptr] : '0;
   assign mem_read_addr  = mem_read_valid ? r_fifo_addr[r_rd_ptr] : '0;
   assign drain_busy     = (r_state != S_IDLE);
   assign drain_done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_obuf_drain.sv
`default_nettype none
// ============================================================================
// Module      : tb_obuf_drain
// Description : Self-checking bench for obuf_drain (default parameters).
// Revision    : 1.0  initial release
// ============================================================================
module tb_obuf_drain;

   logic          clk;
   logic          reset;
   logic          buf_write_req;
   logic [9:0]    buf_write_addr;
   logic [127:0]  buf_write_data;
   logic          drain_start;
   logic [10:0]   drain_base;
   logic [11:0]   drain_count;
   logic          drain_busy;
   logic          drain_done;
   logic          mem_read_valid;
   logic          mem_read_ready;
   logic [63:0]   mem_read_data;
   logic [10:0]   mem_read_addr;

   obuf_drain u_dut (
      .clk            (clk),
      .reset          (reset),
      .buf_write_req  (buf_write_req),
      .buf_write_addr (buf_write_addr),
      .buf_write_data (buf_write_data),
      .drain_start    (drain_start),
      .drain_base     (drain_base),
      .drain_count    (drain_count),
      .drain_busy     (drain_busy),
      .drain_done     (drain_done),
      .mem_read_valid (mem_read_valid),
      .mem_read_ready (mem_read_ready),
      .mem_read_data  (mem_read_data),
      .mem_read_addr  (mem_read_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference bank contents: mdl[column][local address]
   logic [31:0] mdl [0:3][0:1023];

   typedef struct {
      logic [10:0] base;
      logic [10:0] exp_addr;
      logic [63:0] exp_data;
   } vec_t;
   vec_t vecs [8];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] exp_word(input logic [10:0] a);
      logic [9:0] l;
      l = a[10:1];
      if (a[0]) return {mdl[3][l], mdl[2][l]};
      else      return {mdl[1][l], mdl[0][l]};
   endfunction

   // One array write: column n gets its slice n cycles after the request
   task automatic write_row(input logic [9:0] a, input logic [31:0] d0, input logic [31:0] d1,
                            input logic [31:0] d2, input logic [31:0] d3);
      logic [31:0] d [4];
      d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
      buf_write_req  = 1'b1;
      buf_write_addr = a;
      for (int n = 0; n < 4; n++) begin
         buf_write_data = '0;
         buf_write_data[n*32 +: 32] = d[n];
         mdl[n][a] = d[n];
         cyc();
         buf_write_req  = 1'b0;
         buf_write_addr = ~a;
      end
      buf_write_data = '0;
      buf_write_addr = '0;
   endtask

   // Drain with ready high, checking exact cycle-by-cycle behaviour.
   // With poke set, a second start with other parameters arrives while busy.
   task automatic check_drain(input string tag, input logic [10:0] base, input int cnt,
                              input bit poke);
      logic [10:0] a;
      drain_base     = base;
      drain_count    = 12'(cnt);
      drain_start    = 1'b1;
      mem_read_ready = 1'b1;
      for (int k = 1; k <= cnt + 4; k++) begin
         cyc();
         drain_start = 1'b0;
         if (poke && k == 1) begin
            drain_start = 1'b1;
            drain_base  = 11'd10;
            drain_count = 12'd5;
         end
         if (k < 3 || k > cnt + 2) begin
            chk({tag, "_valid_low"}, mem_read_valid, 1'b0);
         end else begin
            a = base + 11'(k - 3);
            chk({tag, "_valid"}, mem_read_valid, 1'b1);
            chk({tag, "_addr"}, mem_read_addr, a);
            chk({tag, "_data"}, mem_read_data, exp_word(a));
         end
         chk({tag, "_busy"}, drain_busy, (k <= cnt + 2));
         chk({tag, "_done"}, drain_done, (k == cnt + 3));
      end
      drain_start = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          idx;
      bit          seen_done;
      logic        pv, pr;
      logic [63:0] pd;
      logic [10:0] pa;

      vecs[0] = '{11'd10,   11'd10,   64'h00000101_00000100};
      vecs[1] = '{11'd11,   11'd11,   64'h00000103_00000102};
      vecs[2] = '{11'd12,   11'd12,   64'h00000201_00000200};
      vecs[3] = '{11'd13,   11'd13,   64'h00000203_00000202};
      vecs[4] = '{11'd2046, 11'd2046, 64'h000000A1_000000A0};
      vecs[5] = '{11'd2047, 11'd2047, 64'h000000A3_000000A2};
      vecs[6] = '{11'd0,    11'd0,    64'h000000B1_000000B0};
      vecs[7] = '{11'd1,    11'd1,    64'h000000B3_000000B2};

      reset          = 1'b0;
      buf_write_req  = 1'b0;
      buf_write_addr = '0;
      buf_write_data = '0;
      drain_start    = 1'b0;
      drain_base     = '0;
      drain_count    = '0;
      mem_read_ready = 1'b1;
      cyc(); cyc();
      chk("rst_busy",  drain_busy,     1'b0);
      chk("rst_done",  drain_done,     1'b0);
      chk("rst_valid", mem_read_valid, 1'b0);
      chk("rst_data",  mem_read_data,  64'h0);
      chk("rst_addr",  mem_read_addr,  11'h0);
      reset = 1'b1;
      cyc();

      write_row(10'd5,    32'h100, 32'h101, 32'h102, 32'h103);
      write_row(10'd6,    32'h200, 32'h201, 32'h202, 32'h203);
      write_row(10'd1023, 32'hA0,  32'hA1,  32'hA2,  32'hA3);
      write_row(10'd0,    32'hB0,  32'hB1,  32'hB2,  32'hB3);
      for (int l = 100; l < 108; l++) begin
         write_row(10'(l), 32'hC000_0000 | 32'(l << 4), 32'hC000_0001 | 32'(l << 4),
                   32'hC000_0002 | 32'(l << 4), 32'hC000_0003 | 32'(l << 4));
      end

      // Single-word drains from the vector table
      for (int i = 0; i < 8; i++) begin
         drain_base  = vecs[i].base;
         drain_count = 12'd1;
         drain_start = 1'b1;
         cyc();
         drain_start = 1'b0;
         chk("vec_busy_t1", drain_busy, 1'b1);
         chk("vec_valid_t1", mem_read_valid, 1'b0);
         cyc();
         chk("vec_valid_t2", mem_read_valid, 1'b0);
         cyc();
         chk("vec_valid_t3", mem_read_valid, 1'b1);
         chk("vec_addr", mem_read_addr, vecs[i].exp_addr);
         chk("vec_data", mem_read_data, vecs[i].exp_data);
         chk("vec_done_t3", drain_done, 1'b0);
         cyc();
         chk("vec_done_t4", drain_done, 1'b1);
         chk("vec_busy_t4", drain_busy, 1'b0);
         chk("vec_valid_t4", mem_read_valid, 1'b0);
         cyc();
         chk("vec_done_t5", drain_done, 1'b0);
      end

      // Two-word drain, then a 16-word streaming drain
      check_drain("two", 11'd10, 2, 1'b0);
      check_drain("burst16", 11'd200, 16, 1'b0);

      // Address wrap, with a start pulse arriving while busy
      check_drain("wrap", 11'd2047, 2, 1'b1);
      for (int k = 0; k < 5; k++) begin
         cyc();
         chk("wrap_no_extra_valid", mem_read_valid, 1'b0);
         chk("wrap_no_extra_busy", drain_busy, 1'b0);
      end

      // Zero-length drain
      drain_base  = 11'd10;
      drain_count = 12'd0;
      drain_start = 1'b1;
      cyc();
      drain_start = 1'b0;
      chk("zero_done", drain_done, 1'b1);
      chk("zero_busy", drain_busy, 1'b0);
      chk("zero_valid", mem_read_valid, 1'b0);
      cyc();
      chk("zero_done_clear", drain_done, 1'b0);
      chk("zero_busy2", drain_busy, 1'b0);
      chk("zero_valid2", mem_read_valid, 1'b0);

      // Stalled drain: ready low for 10 cycles, then toggling
      drain_base     = 11'd200;
      drain_count    = 12'd16;
      drain_start    = 1'b1;
      mem_read_ready = 1'b0;
      cyc();
      drain_start = 1'b0;
      idx = 0; seen_done = 1'b0; pv = 1'b0; pr = 1'b0; pd = '0; pa = '0;
      for (int c = 1; c < 300 && !seen_done; c++) begin
         mem_read_ready = (c >= 11) ? c[0] : 1'b0;
         if (pv && !pr) begin
            chk("stall_hold_valid", mem_read_valid, 1'b1);
            chk("stall_hold_data", mem_read_data, pd);
            chk("stall_hold_addr", mem_read_addr, pa);
         end
         if (mem_read_valid && mem_read_ready) begin
            chk("stall_addr", mem_read_addr, 11'(200 + idx));
            chk("stall_data", mem_read_data, exp_word(11'(200 + idx)));
            idx++;
         end
         if (drain_done) begin
            seen_done = 1'b1;
            chk("stall_words_at_done", 64'(idx), 64'd16);
         end
         pv = mem_read_valid; pr = mem_read_ready; pd = mem_read_data; pa = mem_read_addr;
         if (!seen_done) cyc();
      end
      chk("stall_done_seen", seen_done, 1'b1);
      chk("stall_word_count", 64'(idx), 64'd16);
      mem_read_ready = 1'b1;
      cyc();

      // Reset in the middle of a stalled drain with words queued
      drain_base     = 11'd200;
      drain_count    = 12'd16;
      drain_start    = 1'b1;
      mem_read_ready = 1'b0;
      cyc();
      drain_start = 1'b0;
      cyc(); cyc(); cyc();
      chk("mid_valid_before_reset", mem_read_valid, 1'b1);
      chk("mid_addr_before_reset", mem_read_addr, 11'd200);
      #2;
      reset = 1'b0;
      #1;
      chk("mid_rst_busy",  drain_busy,     1'b0);
      chk("mid_rst_done",  drain_done,     1'b0);
      chk("mid_rst_valid", mem_read_valid, 1'b0);
      chk("mid_rst_data",  mem_read_data,  64'h0);
      chk("mid_rst_addr",  mem_read_addr,  11'h0);
      cyc();
      reset          = 1'b1;
      mem_read_ready = 1'b1;
      cyc();
      chk("post_rst_valid", mem_read_valid, 1'b0);
      chk("post_rst_busy", drain_busy, 1'b0);
      check_drain("post_rst", 11'd10, 2, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
